// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-back front end.
//   NUM_REGS   : number of architectural registers
//   ADDR_W     : register address width
//   DATA_W     : register data width
//   wb_entry_t : one pending register write (destination + data)
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of write-back entries with asynchronous active-high reset.
// Exposes the whole storage array plus a per-slot valid mask so the parent can
// build a pending-register scoreboard.
// Ports:
//   clk, rst    : clock, async active-high reset (pointers only)
//   i_push      : enqueue i_data (ignored when full)
//   i_data      : entry to enqueue
//   i_pop       : dequeue head (ignored when empty)
//   o_head      : current head entry
//   o_count     : occupancy, 0..DEPTH
//   o_full      : occupancy == DEPTH
//   o_empty     : occupancy == 0
//   o_entries   : raw storage slots
//   o_valid     : slot i currently holds a live entry
// -----------------------------------------------------------------------------
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output T [DEPTH-1:0]             o_entries,
    output logic [DEPTH-1:0]         o_valid
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    T              r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_off;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: liveness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        w_off     = '0;
        o_entries = '0;
        o_valid   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entries[i] = r_mem[i];
            w_off        = AW'(i) - r_rd_ptr[AW-1:0];
            o_valid[i]   = ({1'b0, w_off} < o_count);
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
// Writer-side front end for the register file. Serialises ALU results
// (buffered in wb_fifo) and memory-load results (unbuffered, priority) onto the
// single register-file write port, and exports a pending-write scoreboard.
// Optional feature macro: WB_BYPASS_EN -- when defined, an accepted ALU result
// goes straight to the write port if the FIFO is empty and no load is written
// that cycle.
// Ports:
//   clk, rst              : clock, async active-high reset
//   alu_valid/alu_ready   : ALU result handshake
//   alu_reg/alu_data      : ALU destination and data
//   mem_valid/mem_ready   : load result handshake
//   mem_reg/mem_data      : load destination and data
//   writeReg/writeData    : registered write-port address/data
//   write                 : registered write-port enable
//   pending               : bit r set while FIFO holds a write to register r
//   fifo_count            : FIFO occupancy
// -----------------------------------------------------------------------------
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_reg,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_reg,
    input  logic [DATA_W-1:0]          mem_data,
    output logic [ADDR_W-1:0]          writeReg,
    output logic [DATA_W-1:0]          writeData,
    output logic                       write,
    output logic [2**ADDR_W-1:0]       pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    import regfile_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t                  w_head;
    entry_t                  w_in;
    entry_t [DEPTH-1:0]      w_entries;
    logic   [DEPTH-1:0]      w_valid;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_alu_fire;
    logic                    w_alu_nz;
    logic                    w_mem_fire;
    logic                    w_mem_wr;
    logic                    w_bypass;
    logic                    w_push;
    logic                    w_pop;
    logic [2**ADDR_W-1:0]    w_pending;

    logic                    r_write;
    logic [ADDR_W-1:0]       r_write_reg;
    logic [DATA_W-1:0]       r_write_data;

    // Ready is occupancy-only; a same-cycle dequeue grants no extra credit.
    assign alu_ready  = !w_full;
    // Register 0 is never enqueued, so its pending bit is always clear and
    // loads to r0 are always ready.
    assign mem_ready  = !w_pending[mem_reg];

    assign w_alu_fire = alu_valid && alu_ready;
    assign w_alu_nz   = w_alu_fire && (alu_reg != '0);
    assign w_mem_fire = mem_valid && mem_ready;
    assign w_mem_wr   = w_mem_fire && (mem_reg != '0);

`ifdef WB_BYPASS_EN
    assign w_bypass   = w_alu_nz && w_empty && !w_mem_wr;
`else
    assign w_bypass   = 1'b0;
`endif

    assign w_push     = w_alu_nz && !w_bypass;
    assign w_pop      = !w_mem_wr && !w_empty;
    assign w_in       = '{addr: alu_reg, data: alu_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    (w_in),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (fifo_count),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_pending[w_entries[i].addr] = 1'b1;
        end
    end

    assign pending = w_pending;

    // Write-port register: load beats FIFO head beats bypass; address and data
    // hold their last value when nothing is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_mem_wr) begin
            r_write      <= 1'b1;
            r_write_reg  <= mem_reg;
            r_write_data <= mem_data;
        end else if (w_pop) begin
            r_write      <= 1'b1;
            r_write_reg  <= w_head.addr;
            r_write_data <= w_head.data;
        end else if (w_bypass) begin
            r_write      <= 1'b1;
            r_write_reg  <= alu_reg;
            r_write_data <= alu_data;
        end else begin
            r_write      <= 1'b0;
        end
    end

    assign write     = r_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
// Self-checking bench: a queue-based reference model tracks the expected write
// port, readiness, occupancy and scoreboard each cycle.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              mem_valid = 1'b0;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_reg = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              write;
    logic [31:0]       pending;
    logic [2:0]        fifo_count;

    regfile_writeback #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .write      (write),
        .pending    (pending),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    bit                exp_write;
    logic [ADDR_W-1:0] exp_reg;
    logic [DATA_W-1:0] exp_data;
    bit                last_alu_acc;
    bit                last_mem_acc;
    int                checks = 0;
    int                errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_q(input logic [ADDR_W-1:0] r);
        foreach (q[i]) if (q[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].r] = 1'b1;
        return p;
    endfunction

    task automatic check_outs();
        chk("write", write, exp_write);
        chk("writeReg", writeReg, exp_reg);
        chk("writeData", writeData, exp_data);
        chk("fifo_count", fifo_count, q.size());
        chk("pending", pending, exp_pending());
    endtask

    // Called just after a falling edge: apply inputs, check readiness, advance
    // the model across the next rising edge, then check registered outputs.
    task automatic step(input bit av, input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                        input bit mv, input logic [ADDR_W-1:0] mr, input logic [DATA_W-1:0] md);
        bit ea, em, byp;
        ent_t e;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        #1;
        ea = (q.size() < DEPTH);
        em = (mr == 0) || !in_q(mr);
        chk("alu_ready", alu_ready, ea);
        chk("mem_ready", mem_ready, em);
        last_alu_acc = av && ea;
        last_mem_acc = mv && em;
        byp = 1'b0;
        exp_write = 1'b0;
        if (last_mem_acc && mr != 0) begin
            exp_write = 1'b1; exp_reg = mr; exp_data = md;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            exp_write = 1'b1; exp_reg = e.r; exp_data = e.d;
        end else if (BYP && last_alu_acc && ar != 0) begin
            byp = 1'b1;
            exp_write = 1'b1; exp_reg = ar; exp_data = ad;
        end
        if (last_alu_acc && ar != 0 && !byp) q.push_back('{r: ar, d: ad});
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && q.size() > 0; i++) idle();
        chk("drain_empty", fifo_count, 0);
    endtask

    initial begin
        bit done;
        exp_write = 1'b0; exp_reg = '0; exp_data = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_write", write, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ready", alu_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check_outs();

        // ALU only: r3 = 0x11
        step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
        chk("alu_lat_n1", write, BYP);
        idle();
        chk("alu_lat_n2", write, !BYP);
        chk("alu_reg", writeReg, 3);
        chk("alu_data", writeData, 32'h11);
        drain();

        // Priority: r4 queued behind an unrelated load, then load r7 wins
        step(1'b1, 5'd4, 32'hA, 1'b1, 5'd8, 32'h8);
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hB);
        chk("prio_first", writeReg, 7);
        idle();
        chk("prio_second", writeReg, 4);
        drain();

        // WAW: r5 queued, load to r5 must wait
        step(1'b1, 5'd5, 32'h1, 1'b1, 5'd9, 32'h9);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(1'b0, '0, '0, 1'b1, 5'd5, 32'h2);
            done = last_mem_acc;
        end
        chk("waw_accepted", done, 1);
        chk("waw_last_reg", writeReg, 5);
        chk("waw_last_data", writeData, 32'h2);
        drain();

        // Full: four ALU writes while loads occupy the port
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'(100 + i), 1'b1, 5'(20 + i), 32'(200 + i));
        chk("full_count", fifo_count, 4);
        chk("full_ready", alu_ready, 0);
        step(1'b1, 5'd14, 32'd104, 1'b1, 5'd24, 32'd204);
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(1'b1, 5'd14, 32'd104, 1'b0, '0, '0);
            done = last_alu_acc;
        end
        chk("full_fifth_accepted", done, 1);
        drain();

        // Register zero
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        chk("r0_nowrite", write, 0);
        chk("r0_pending", pending[0], 0);

        // Randomized traffic over a small register window to create hazards
        for (int n = 0; n < 1500; n++)
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
        drain();

        // Reset mid-stream with three entries queued
        step(1'b1, 5'd1, 32'h51, 1'b1, 5'd20, 32'h60);
        step(1'b1, 5'd2, 32'h52, 1'b1, 5'd21, 32'h61);
        step(1'b1, 5'd3, 32'h53, 1'b1, 5'd22, 32'h62);
        chk("prerst_count", fifo_count, 3);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_write", write, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_reg", writeReg, 0);
        q.delete();
        exp_write = 1'b0; exp_reg = '0; exp_data = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side front end for the 32x32 register file.
- Accepts results from two producers and serialises them onto the register file's single write port (writeReg/writeData/write):
  - ALU producer: buffered in a FIFO.
  - Memory-load producer: priority path, unbuffered.
- Exports a pending-write scoreboard so decode and hazard logic can see which registers still have writes in flight.

Parameters:
- DEPTH, 4, ALU result FIFO depth in entries; power of two, minimum 2.
- DATA_W, 32, result data width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
- alu_reg  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_valid  input  1  load result offered.
- mem_ready  output  1  load result accepted when mem_valid && mem_ready.
- mem_reg  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load result.
- writeReg  output  ADDR_W  register-file write address, registered.
- writeData  output  DATA_W  register-file write data, registered.
- write  output  1  register-file write enable, registered.
- pending  output  2**ADDR_W  bit r set while the FIFO holds a write to register r.
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, effective immediately):
  - write=0, writeReg=0, writeData=0.
  - FIFO emptied, fifo_count=0, pending=0.
- alu_ready = (fifo_count < DEPTH).
  - Purely occupancy-based: no same-cycle credit from a dequeue.
- Register 0: an accepted ALU or mem result with reg==0 is consumed and discarded. It is never enqueued or written, and never sets pending.
- mem_ready = !pending[mem_reg].
  - A load may not overtake an older queued ALU write to the same register (WAW ordering).
  - mem_reg==0 is always ready.
- Write-port arbitration, evaluated each cycle. Exactly one source (or none) is registered at the edge:
  1. Accepted mem result (reg!=0) -> write=1, writeReg=mem_reg, writeData=mem_data.
  2. Else, FIFO non-empty -> dequeue the head; write=1 with the head's reg/data.
  3. Else -> write=0. writeReg/writeData hold their previous values.
- Latency:
  - Mem: accepted in cycle N -> write asserted in cycle N+1.
  - ALU via FIFO: accepted in cycle N -> earliest write in cycle N+2.
- Simultaneous enqueue and dequeue in the same cycle: fifo_count is unchanged and the ordering of data is preserved.
- FIFO ordering: strict FIFO. Multiple entries to the same register are allowed and are written oldest-first.
- pending: combinational OR of the one-hot-decoded reg fields of all valid FIFO entries.
  - A bit clears in the cycle after its last entry is dequeued.
- Starvation: continuous mem traffic can starve the FIFO. This is accepted by design; the upstream load rate is bounded.
- Wrap-around: read/write pointers are ADDR bits plus one extra bit; full/empty are distinguished by the MSB.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - An accepted ALU result (reg!=0) goes straight to the write-port registers, skipping the FIFO, when all of the following hold:
    - the FIFO is empty;
    - no mem result is accepted in that cycle.
  - ALU latency in that case becomes N+1.
  - pending never reflects bypassed entries.
- Undefined: every ALU result passes through the FIFO (minimum latency N+2).

Decomposition:
- Shared package regfile_pkg:
  - constants NUM_REGS=32, ADDR_W=5, DATA_W=32;
  - typedef wb_entry_t {reg addr, data}.
- One natural sub-module: wb_fifo.
  - Parameterised synchronous FIFO of wb_entry_t, async active-high reset.
  - Outputs: count, full, empty, plus the entry array for the pending decode.

Test Plan:
- Reset: assert rst mid-stream with 3 entries queued -> write=0 immediately, fifo_count=0, pending=0; no write after release.
- ALU only: alu r3=0x11 at cycle 1 -> write=1, writeReg=3, writeData=0x11 in cycle 3 (cycle 2 if WB_BYPASS_EN).
- Priority: FIFO holds r4=0xA; mem r7=0xB accepted at the same cycle -> r7 written first, then r4 the next cycle.
- WAW hazard: FIFO holds r5=0x1; mem_valid with mem_reg=5 -> mem_ready=0 until r5 has been written; then the load writes r5=0x2 last.
- Full: 4 ALU writes with no drain possible (mem busy to other registers) -> fifo_count=4, alu_ready=0; a 5th offer is held until a dequeue, and no data is lost.
- Register zero: alu r0 and mem r0 accepted -> no write pulse, pending[0]=0, fifo_count unchanged.
